fc_layer_scheduler: RTL and testbench

Sequencer that computes one fully connected layer of the VGG16 classifier head on a single shared serial floating-point MAC engine. On a start pulse it walks all output neurons, streaming data/weight read addresses to the input, weight and bias memories, tagging each beat with first/last flags for the engine. It then collects the engine's per-neuron results and writes them in order into the layer output buffer. It sits between the layer-level control FSM and the MAC engine/memories.

---
 rtl/fc_pkg.sv | 18 +
 rtl/fc_addr_gen.sv | 62 ++++++
 rtl/fc_layer_scheduler.sv | 152 +++++++++++++++
 tb/tb_fc_layer_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared constants, FSM state type and address-width helper for the FC layer scheduler.
package fc_pkg;

   localparam int unsigned FP32_W = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } fc_state_t;

   // Address width for an n-entry memory; never narrower than one bit.
   function automatic int unsigned addr_w(input int unsigned n);
      return (n <= 32'd2) ? 32'd1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// fc_addr_gen: input/neuron/weight beat counters for the FC scheduler, advancing once per issued beat.
module fc_addr_gen
   import fc_pkg::*;
#(
   parameter int unsigned IN    = 5,
   parameter int unsigned OUT   = 4,
   parameter int unsigned IN_W  = addr_w(IN),
   parameter int unsigned OUT_W = addr_w(OUT),
   parameter int unsigned W_W   = addr_w(IN * OUT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [IN_W-1:0]  in_cnt_o,
   output logic [OUT_W-1:0] out_cnt_o,
   output logic [W_W-1:0]   w_addr_o,
   output logic             last_beat_o
);

   logic [IN_W-1:0]  in_q,  in_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic [W_W-1:0]   w_q,   w_d;

   // Weights are neuron-major, so a plain running counter replaces out_cnt*IN+in_cnt.
   always_comb begin
      in_d  = in_q;
      out_d = out_q;
      w_d   = w_q;
      if (clr_i) begin
         in_d  = '0;
         out_d = '0;
         w_d   = '0;
      end else if (en_i) begin
         if (in_q == IN_W'(IN - 1)) begin
            in_d  = '0;
            out_d = (out_q == OUT_W'(OUT - 1)) ? '0 : out_q + 1'b1;
         end else begin
            in_d = in_q + 1'b1;
         end
         w_d = (w_q == W_W'(IN * OUT - 1)) ? '0 : w_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q  <= '0;
         out_q <= '0;
         w_q   <= '0;
      end else begin
         in_q  <= in_d;
         out_q <= out_d;
         w_q   <= w_d;
      end
   end

   assign in_cnt_o    = in_q;
   assign out_cnt_o   = out_q;
   assign w_addr_o    = w_q;
   assign last_beat_o = (in_q == IN_W'(IN - 1)) && (out_q == OUT_W'(OUT - 1));

endmodule

// File: rtl/fc_layer_scheduler.sv
// fc_layer_scheduler: sequences one FC layer over a shared serial MAC and writes neuron results back in order.
// Define FC_SCHED_RELU_EN to write zero for any result with its sign bit set (fused ReLU).
module fc_layer_scheduler
   import fc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH         = FP32_W,
   parameter int unsigned NUMBER_INPUT_NODE  = 5,
   parameter int unsigned NUMBER_OUTPUT_NODE = 4
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   input  logic                                                   i_start,
   input  logic                                                   i_engine_ready,
   input  logic                                                   i_result_valid,
   input  logic [DATA_WIDTH-1:0]                                  i_result,
   output logic                                                   o_busy,
   output logic                                                   o_done,
   output logic                                                   o_rd_en,
   output logic [addr_w(NUMBER_INPUT_NODE)-1:0]                   o_data_addr,
   output logic [addr_w(NUMBER_INPUT_NODE*NUMBER_OUTPUT_NODE)-1:0] o_weight_addr,
   output logic [addr_w(NUMBER_OUTPUT_NODE)-1:0]                  o_bias_addr,
   output logic                                                   o_mac_valid,
   output logic                                                   o_mac_first,
   output logic                                                   o_mac_last,
   output logic                                                   o_wr_en,
   output logic [addr_w(NUMBER_OUTPUT_NODE)-1:0]                  o_wr_addr,
   output logic [DATA_WIDTH-1:0]                                  o_wr_data
);

   localparam int unsigned IN_W  = addr_w(NUMBER_INPUT_NODE);
   localparam int unsigned OUT_W = addr_w(NUMBER_OUTPUT_NODE);
   localparam int unsigned W_W   = addr_w(NUMBER_INPUT_NODE * NUMBER_OUTPUT_NODE);

   fc_state_t state_q, state_d;

   logic             fire, clr, wr_fire, final_wr, last_beat;
   logic [IN_W-1:0]  in_cnt;
   logic [OUT_W-1:0] out_cnt;
   logic [W_W-1:0]   w_addr;
   logic [OUT_W-1:0] wr_cnt_q;
   logic [DATA_WIDTH-1:0] wr_data;

   logic                  busy_q, done_q, rd_en_q, mac_valid_q, mac_first_q, mac_last_q, wr_en_q;
   logic [IN_W-1:0]       data_addr_q;
   logic [W_W-1:0]        weight_addr_q;
   logic [OUT_W-1:0]      bias_addr_q, wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;

   fc_addr_gen #(
      .IN    (NUMBER_INPUT_NODE),
      .OUT   (NUMBER_OUTPUT_NODE),
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .W_W   (W_W)
   ) u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (clr),
      .en_i        (fire),
      .in_cnt_o    (in_cnt),
      .out_cnt_o   (out_cnt),
      .w_addr_o    (w_addr),
      .last_beat_o (last_beat)
   );

`ifdef FC_SCHED_RELU_EN
   assign wr_data = i_result[DATA_WIDTH-1] ? '0 : i_result;
`else
   assign wr_data = i_result;
`endif

   // The first beat issues on the start edge itself so o_rd_en rises together with o_busy.
   always_comb begin
      state_d  = state_q;
      fire     = 1'b0;
      clr      = 1'b0;
      wr_fire  = i_result_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
      final_wr = wr_fire && (wr_cnt_q == OUT_W'(NUMBER_OUTPUT_NODE - 1));
      case (state_q)
         S_IDLE: begin
            clr = !i_start;
            if (i_start) begin
               state_d = S_ISSUE;
               fire    = i_engine_ready;
            end
         end
         S_ISSUE: begin
            fire = i_engine_ready;
            if (fire && last_beat) state_d = final_wr ? S_DONE : S_DRAIN;
         end
         S_DRAIN: if (final_wr) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         rd_en_q       <= 1'b0;
         data_addr_q   <= '0;
         weight_addr_q <= '0;
         bias_addr_q   <= '0;
         mac_valid_q   <= 1'b0;
         mac_first_q   <= 1'b0;
         mac_last_q    <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         wr_cnt_q      <= '0;
      end else begin
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_q == S_DONE);
         rd_en_q <= fire;
         if (fire) begin
            data_addr_q   <= in_cnt;
            weight_addr_q <= w_addr;
            bias_addr_q   <= out_cnt;
         end
         mac_valid_q <= rd_en_q;
         mac_first_q <= rd_en_q && (data_addr_q == '0);
         mac_last_q  <= rd_en_q && (data_addr_q == IN_W'(NUMBER_INPUT_NODE - 1));
         wr_en_q     <= wr_fire;
         if (wr_fire) begin
            wr_addr_q <= wr_cnt_q;
            wr_data_q <= wr_data;
         end
         if (state_q == S_IDLE) wr_cnt_q <= '0;
         else if (wr_fire)      wr_cnt_q <= wr_cnt_q + 1'b1;
      end
   end

   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_rd_en       = rd_en_q;
   assign o_data_addr   = data_addr_q;
   assign o_weight_addr = weight_addr_q;
   assign o_bias_addr   = bias_addr_q;
   assign o_mac_valid   = mac_valid_q;
   assign o_mac_first   = mac_first_q;
   assign o_mac_last    = mac_last_q;
   assign o_wr_en       = wr_en_q;
   assign o_wr_addr     = wr_addr_q;
   assign o_wr_data     = wr_data_q;

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// tb_fc_layer_scheduler: self-checking bench for fc_layer_scheduler (IN=5/OUT=4 main instance, OUT=1 corner instance).
module tb_fc_layer_scheduler;

   localparam int IN  = 5;
   localparam int OUT = 4;
   localparam int TOT = IN * OUT;
`ifdef FC_SCHED_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   typedef struct { logic [31:0] res; logic [31:0] exp; } vec_t;
   typedef struct { logic [1:0] addr; logic [31:0] data; } wr_t;

   vec_t tbl [OUT];
   wr_t  sb [$];

   int n_vec = 0, n_bad = 0;
   int beats = 0, done_cnt = 0;
   int beat_k = 0, prev_k = 0;
   logic prev_rd = 1'b0, prev_wr = 1'b0;
   logic [1:0] prev_wr_addr = '0;
   bit tog_stop;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic        rst, start, ready, eng_rv, tb_rv, rv;
   logic [31:0] eng_res, tb_res, res;
   logic        busy, done, rd_en, mac_valid, mac_first, mac_last, wr_en;
   logic [2:0]  data_addr;
   logic [4:0]  weight_addr;
   logic [1:0]  bias_addr, wr_addr;
   logic [31:0] wr_data;

   assign rv  = eng_rv | tb_rv;
   assign res = tb_rv ? tb_res : eng_res;

   fc_layer_scheduler #(.DATA_WIDTH(32), .NUMBER_INPUT_NODE(IN), .NUMBER_OUTPUT_NODE(OUT)) dut (
      .clk(clk), .rst(rst), .i_start(start), .i_engine_ready(ready),
      .i_result_valid(rv), .i_result(res),
      .o_busy(busy), .o_done(done), .o_rd_en(rd_en),
      .o_data_addr(data_addr), .o_weight_addr(weight_addr), .o_bias_addr(bias_addr),
      .o_mac_valid(mac_valid), .o_mac_first(mac_first), .o_mac_last(mac_last),
      .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data)
   );

   // single-neuron instance
   logic        rstb, startb, readyb, rvb;
   logic [31:0] resb;
   logic        busyb, doneb, rd_enb, mac_validb, mac_firstb, mac_lastb, wr_enb;
   logic [2:0]  data_addrb, weight_addrb;
   logic [0:0]  bias_addrb, wr_addrb;
   logic [31:0] wr_datab;

   fc_layer_scheduler #(.DATA_WIDTH(32), .NUMBER_INPUT_NODE(IN), .NUMBER_OUTPUT_NODE(1)) dut_b (
      .clk(clk), .rst(rstb), .i_start(startb), .i_engine_ready(readyb),
      .i_result_valid(rvb), .i_result(resb),
      .o_busy(busyb), .o_done(doneb), .o_rd_en(rd_enb),
      .o_data_addr(data_addrb), .o_weight_addr(weight_addrb), .o_bias_addr(bias_addrb),
      .o_mac_valid(mac_validb), .o_mac_first(mac_firstb), .o_mac_last(mac_lastb),
      .o_wr_en(wr_enb), .o_wr_addr(wr_addrb), .o_wr_data(wr_datab)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Engine stand-in: returns table row i three cycles after the i-th last beat.
   task automatic run_engine();
      int t;
      for (int i = 0; i < OUT; i++) begin
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!(mac_valid && mac_last) && t < 300);
         check("engine_last_beat_seen", 64'(t < 300), 1);
         repeat (3) @(negedge clk);
         eng_rv  = 1'b1;
         eng_res = tbl[i].res;
         sb.push_back('{addr: 2'(i), data: tbl[i].exp});
         @(negedge clk);
         eng_rv = 1'b0;
      end
   endtask

   task automatic wait_done(input int d0);
      int t;
      t = 0;
      while (done_cnt == d0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check("done_pulse_count", 64'(done_cnt - d0), 1);
   endtask

   // Monitor for the main instance: beat address model, mac qualifier alignment, write scoreboard.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            beat_k  = 0;
            prev_rd = 1'b0;
            prev_wr = 1'b0;
            sb.delete();
         end else begin
            check("mac_valid_follows_rd_en", 64'(mac_valid), 64'(prev_rd));
            if (mac_valid) begin
               check("mac_first", 64'(mac_first), 64'((prev_k % IN) == 0));
               check("mac_last", 64'(mac_last), 64'((prev_k % IN) == IN - 1));
            end
            if (rd_en) begin
               check("data_addr", 64'(data_addr), 64'(beat_k % IN));
               check("weight_addr", 64'(weight_addr), 64'(beat_k));
               check("bias_addr", 64'(bias_addr), 64'(beat_k / IN));
               prev_k = beat_k;
               beat_k = (beat_k + 1) % TOT;
               beats++;
            end
            prev_rd = rd_en;
            if (wr_en) begin
               if (sb.size() == 0) begin
                  check("unexpected_write", 64'(wr_en), 0);
               end else begin
                  e = sb.pop_front();
                  check("wr_addr", 64'(wr_addr), 64'(e.addr));
                  check("wr_data", 64'(wr_data), 64'(e.data));
               end
            end
            if (done) begin
               check("done_after_last_wr", 64'({prev_wr, prev_wr_addr}), 64'({1'b1, 2'(OUT - 1)}));
               done_cnt++;
            end
            prev_wr      = wr_en;
            prev_wr_addr = wr_addr;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int b0, d0, t;
      tbl[0] = '{res: 32'h3F80_0000, exp: 32'h3F80_0000};
      tbl[1] = '{res: 32'hC000_0000, exp: RELU ? 32'h0 : 32'hC000_0000};
      tbl[2] = '{res: 32'h8000_0000, exp: RELU ? 32'h0 : 32'h8000_0000};
      tbl[3] = '{res: 32'h4120_0000, exp: 32'h4120_0000};

      rst = 1'b1; start = 1'b0; ready = 1'b1; eng_rv = 1'b0; tb_rv = 1'b0;
      eng_res = '0; tb_res = '0;
      rstb = 1'b1; startb = 1'b0; readyb = 1'b1; rvb = 1'b0; resb = '0;
      #3;
      check("reset_busy_done_rd", 64'({busy, done, rd_en}), 0);
      check("reset_addrs", 64'({data_addr, weight_addr, bias_addr}), 0);
      check("reset_mac", 64'({mac_valid, mac_first, mac_last}), 0);
      check("reset_wr", 64'({wr_en, wr_addr, wr_data}), 0);
      @(negedge clk); #2 rst = 1'b0; rstb = 1'b0;

      // layer with ready held high, plus a stray start mid-ISSUE
      b0 = beats; d0 = done_cnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("busy_cycle1", 64'(busy), 1);
      check("rd_en_cycle1", 64'(rd_en), 1);
      fork
         run_engine();
         begin
            repeat (8) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      wait_done(d0);
      check("beats_layer_ready_high", 64'(beats - b0), TOT);

      // result strobe while idle must not write
      tb_rv = 1'b1; tb_res = 32'h1234_5678;
      @(negedge clk); tb_rv = 1'b0;
      check("idle_result_no_wr", 64'(wr_en), 0);
      check("idle_not_busy", 64'(busy), 0);

      // ready toggling 1010...
      b0 = beats; d0 = done_cnt; tog_stop = 1'b0;
      @(negedge clk); start = 1'b1; ready = 1'b1;
      @(negedge clk); start = 1'b0;
      fork
         begin
            for (int c = 0; c < 400 && !tog_stop; c++) begin
               ready = ~ready;
               @(negedge clk);
            end
         end
         begin
            run_engine();
            wait_done(d0);
            tog_stop = 1'b1;
         end
      join
      ready = 1'b1;
      check("beats_layer_ready_toggle", 64'(beats - b0), TOT);

      // reset at beat 7, then restart from weight 0
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      t = 0;
      while (!(rd_en && weight_addr == 5'd7) && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("beat7_reached", 64'(weight_addr), 7);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy_done_rd", 64'({busy, done, rd_en}), 0);
      check("midrst_addrs", 64'({data_addr, weight_addr, bias_addr}), 0);
      check("midrst_mac_wr", 64'({mac_valid, mac_first, mac_last, wr_en, wr_addr}), 0);
      @(negedge clk); #2 rst = 1'b0;
      b0 = beats; d0 = done_cnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("restart_rd_en", 64'(rd_en), 1);
      check("restart_weight0", 64'(weight_addr), 0);
      run_engine();
      wait_done(d0);
      check("beats_after_restart", 64'(beats - b0), TOT);

      // OUT=1: result lands in the last ISSUE cycle, straight to DONE
      @(negedge clk); startb = 1'b1;
      @(negedge clk); startb = 1'b0;
      check("b_busy_cycle1", 64'({busyb, rd_enb}), 64'(2'b11));
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); rvb = 1'b1; resb = 32'h3F80_0000;
      check("b_issue_last_cycle_waddr", 64'({rd_enb, weight_addrb}), 64'({1'b1, 3'd3}));
      @(negedge clk); rvb = 1'b0;
      check("b_wr", 64'({wr_enb, wr_addrb}), 64'(2'b10));
      check("b_wr_data", 64'(wr_datab), 64'(32'h3F80_0000));
      check("b_last_beat_done_low", 64'({rd_enb, weight_addrb, doneb, busyb}), 64'({1'b1, 3'd4, 1'b0, 1'b1}));
      @(negedge clk);
      check("b_done_pulse", 64'({doneb, busyb, wr_enb}), 64'(3'b100));
      check("b_mac_last", 64'({mac_validb, mac_lastb}), 64'(2'b11));
      @(negedge clk);
      check("b_done_single", 64'({doneb, busyb}), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
